serial_divider: RTL and testbench

- Sequential unsigned restoring divider; the inverse companion to the lab's shift-add multiplier.
- Uses the same switch-and-button style: S supplies operands, LoadDivisor latches the divisor, Run starts one division.
- Produces one quotient bit per clock and sits in the lab top level beside the multiplier, driving the hex displays.

---
 rtl/serial_divider_pkg.sv | 13 +
 rtl/div_step.sv | 35 +++
 rtl/serial_divider.sv | 121 ++++++++++++
 tb/tb_serial_divider.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_divider_pkg.sv
// Shared types and defaults for the serial restoring divider.
// Imported by the top level and its iteration datapath.
package serial_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left and conditionally
// subtract the divisor, shifting the accepted quotient bit into Q.
import serial_divider_pkg::*;

module div_step #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   A,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH:0]   A_next,
    output logic [WIDTH-1:0] Q_next
);

    logic [2*WIDTH:0] sh;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   t;

    always_comb begin
        sh   = {A, Q} << 1;
        a_sh = sh[2*WIDTH:WIDTH];
        q_sh = sh[WIDTH-1:0];
        t    = a_sh - {1'b0, D};
        // Sign bit clear means the divisor fit: keep the difference.
        if (!t[WIDTH]) begin
            A_next = t;
            Q_next = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            A_next = a_sh;
            Q_next = q_sh;
        end
    end

endmodule

// File: rtl/serial_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Switch operand S feeds the divisor on LoadDivisor, the dividend on Run.
import serial_divider_pkg::*;

module serial_divider #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] S,
    input  logic             LoadDivisor,
    input  logic             Run,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .A      (a_q),
        .Q      (q_q),
        .D      (d_q),
        .A_next (a_next),
        .Q_next (q_next)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (LoadDivisor) begin
                    d_d = S;
                end else if (Run) begin
                    if (d_q != '0) begin
                        a_d     = '0;
                        q_d     = S;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = COMPUTE;
                    end else begin
                        quot_d  = '1;
                        rem_d   = S;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            COMPUTE: begin
                a_d   = a_next;
                q_d   = q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quot_d  = q_next;
                    rem_d   = a_next[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivByZero = dbz_q;
    assign Busy      = (state_q == COMPUTE);
    assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_divider.sv
// Directed-vector bench for serial_divider with hand-computed results.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serial_divider;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] S;
    logic       LoadDivisor;
    logic       Run;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivByZero;

    int n_cmp = 0;
    int n_bad = 0;

    serial_divider #(.WIDTH(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .S           (S),
        .LoadDivisor (LoadDivisor),
        .Run         (Run),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Busy        (Busy),
        .Done        (Done),
        .DivByZero   (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_div(input logic [7:0] v);
        S = v;
        LoadDivisor = 1'b1;
        tick();
        LoadDivisor = 1'b0;
    endtask

    // Pulse Run for one edge; returns edges from start edge to Done.
    // Leaves the DUT in DONE with Run low.
    task automatic run_div(input logic [7:0] v, output int lat);
        S = v;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        lat = 0;
        while (!Done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        n_cmp++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got q=%0d r=%0d b=%b d=%b z=%b want 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
    endtask

    task automatic test_basic();
        int lat;
        int busy_n;
        load_div(8'd7);
        S = 8'd200;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!Done && lat < 40) begin
            if (Busy) busy_n++;
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        n_cmp++;
        if (busy_n !== 8) begin
            n_bad++;
            $display("FAIL basic_busy_cycles got %0d want 8", busy_n);
        end
        n_cmp++;
        if ({Quotient, Remainder, DivByZero} !== {8'd28, 8'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_200_7 got q=%0d r=%0d z=%b want 28 4 0",
                     Quotient, Remainder, DivByZero);
        end
        tick();
        n_cmp++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_idle got d=%b b=%b want 0 0", Done, Busy);
        end
    endtask

    task automatic test_hold_prev();
        int lat;
        load_div(8'd1);
        run_div(8'd255, lat);
        n_cmp++;
        if ({Quotient, Remainder} !== {8'd255, 8'd0}) begin
            n_bad++;
            $display("FAIL div_255_1 got q=%0d r=%0d want 255 0",
                     Quotient, Remainder);
        end
        tick();
        load_div(8'd9);
        S = 8'd5;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({Busy, Quotient, Remainder} !== {1'b1, 8'd255, 8'd0}) begin
            n_bad++;
            $display("FAIL hold_prev got b=%b q=%0d r=%0d want 1 255 0",
                     Busy, Quotient, Remainder);
        end
        lat = 0;
        while (!Done && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if ({Quotient, Remainder} !== {8'd0, 8'd5}) begin
            n_bad++;
            $display("FAIL div_5_9 got q=%0d r=%0d want 0 5",
                     Quotient, Remainder);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int lat;
        load_div(8'd0);
        run_div(8'h2A, lat);
        n_cmp++;
        if (lat !== 0) begin
            n_bad++;
            $display("FAIL dbz_latency got %0d want 0", lat);
        end
        n_cmp++;
        if ({Quotient, Remainder, DivByZero} !== {8'hFF, 8'h2A, 1'b1}) begin
            n_bad++;
            $display("FAIL dbz_result got q=%h r=%h z=%b want ff 2a 1",
                     Quotient, Remainder, DivByZero);
        end
        tick();
        load_div(8'd7);
        run_div(8'd50, lat);
        n_cmp++;
        if ({Quotient, Remainder, DivByZero} !== {8'd7, 8'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL dbz_clear got q=%0d r=%0d z=%b want 7 1 0",
                     Quotient, Remainder, DivByZero);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int busy_n;
        int lat;
        load_div(8'd3);
        S = 8'd10;
        Run = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Busy) busy_n++;
        end
        n_cmp++;
        if (busy_n !== 8) begin
            n_bad++;
            $display("FAIL held_run_busy got %0d want 8", busy_n);
        end
        n_cmp++;
        if ({Done, Quotient, Remainder} !== {1'b1, 8'd3, 8'd1}) begin
            n_bad++;
            $display("FAIL held_run_result got d=%b q=%0d r=%0d want 1 3 1",
                     Done, Quotient, Remainder);
        end
        Run = 1'b0;
        tick();
        n_cmp++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL held_run_idle got d=%b b=%b want 0 0", Done, Busy);
        end
        run_div(8'd17, lat);
        n_cmp++;
        if ({lat, Quotient, Remainder} !== {32'd8, 8'd5, 8'd2}) begin
            n_bad++;
            $display("FAIL second_run got lat=%0d q=%0d r=%0d want 8 5 2",
                     lat, Quotient, Remainder);
        end
        tick();
    endtask

    task automatic test_load_mid();
        int lat;
        load_div(8'd10);
        S = 8'd100;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        S = 8'd2;
        LoadDivisor = 1'b1;
        tick();
        LoadDivisor = 1'b0;
        lat = 0;
        while (!Done && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if ({Quotient, Remainder} !== {8'd10, 8'd0}) begin
            n_bad++;
            $display("FAIL load_mid got q=%0d r=%0d want 10 0",
                     Quotient, Remainder);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        load_div(8'd7);
        S = 8'd200;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_cmp++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_mid got q=%0d r=%0d b=%b d=%b z=%b want 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        tick();
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_idle got b=%b d=%b want 0 0", Busy, Done);
        end
        run_div(8'd5, lat);
        n_cmp++;
        if ({lat, Quotient, DivByZero} !== {32'd0, 8'hFF, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_clears_d got lat=%0d q=%h z=%b want 0 ff 1",
                     lat, Quotient, DivByZero);
        end
        tick();
    endtask

    task automatic test_load_run_same();
        int lat;
        S = 8'd6;
        LoadDivisor = 1'b1;
        Run = 1'b1;
        tick();
        LoadDivisor = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL load_wins got b=%b d=%b want 0 0", Busy, Done);
        end
        tick();
        Run = 1'b0;
        n_cmp++;
        if (Busy !== 1'b1) begin
            n_bad++;
            $display("FAIL load_run_start got b=%b want 1", Busy);
        end
        lat = 0;
        while (!Done && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if ({Quotient, Remainder, DivByZero} !== {8'd1, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL load_run_result got q=%0d r=%0d z=%b want 1 0 0",
                     Quotient, Remainder, DivByZero);
        end
        tick();
    endtask

    initial begin
        Reset = 1'b1;
        S = '0;
        LoadDivisor = 1'b0;
        Run = 1'b0;
        test_reset();
        test_basic();
        test_hold_prev();
        test_div_zero();
        test_back_to_back();
        test_load_mid();
        test_reset_mid();
        test_load_run_same();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
